// File: rtl/zeroriscy_data_arbiter_if.sv
// ----------------------------------------------------------------------------
// zeroriscy_data_arbiter_if
//
// Purpose: one req/gnt/rvalid data-memory port as used by the zero-riscy
// LSU. It is used for each master port and for the shared downstream port.
//
// Signals:
//   req    requester -> responder  request, held with its fields until gnt
//   addr   requester -> responder  32-bit byte address
//   we     requester -> responder  write enable
//   be     requester -> responder  4-bit byte enables
//   wdata  requester -> responder  32-bit write data
//   gnt    responder -> requester  request accepted
//   rvalid responder -> requester  response valid, in grant order
//   rdata  responder -> requester  32-bit read data
//   err    responder -> requester  bus error, qualified by rvalid
//
// Modports:
//   master  the side that issues requests
//   slave   the side that accepts requests and returns responses
// ----------------------------------------------------------------------------
interface zeroriscy_data_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/zeroriscy_data_arbiter.sv
// ----------------------------------------------------------------------------
// zeroriscy_data_arbiter
//
// Purpose: shares one data-memory port between the zero-riscy LSU (m0) and
// a second master (m1). Requests pass through combinationally. An owner FIFO
// records the master behind each granted transaction so every response goes
// back to the master that issued it.
//
// Parameters:
//   MAX_OUTSTANDING  owner FIFO depth = max granted transactions still
//                    waiting for rvalid (1..4)
//
// Ports:
//   clk                in   core clock
//   rst_n              in   asynchronous active-low reset
//   m0                 slave modport  master 0 (core LSU)
//   m1                 slave modport  master 1 (second master)
//   data               master modport downstream memory / interconnect
//   spurious_rvalid_o  out  sticky: rvalid received with no transaction
//                           outstanding (cleared only by reset)
//
// Configuration macro:
//   ZERORISCY_DATA_ARB_RR_EN  defined   -> round-robin tie-break
//                             undefined -> fixed priority, m0 wins
// ----------------------------------------------------------------------------
module zeroriscy_data_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  zeroriscy_data_arbiter_if.slave         m0,
  zeroriscy_data_arbiter_if.slave         m1,
  zeroriscy_data_arbiter_if.master        data,
  output logic                            spurious_rvalid_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  // Pointers wrap modulo the depth, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // State
  logic                       lock_valid_r;
  logic                       lock_id_r;
  logic [MAX_OUTSTANDING-1:0] owner_r;
  logic [PTR_W-1:0]           wptr_r;
  logic [PTR_W-1:0]           rptr_r;
  logic [CNT_W-1:0]           count_r;
  logic                       spurious_r;
`ifdef ZERORISCY_DATA_ARB_RR_EN
  logic                       last_gnt_r;
`endif

  // Combinational decisions
  logic sel_id_s;
  logic sel_valid_s;
  logic full_s;
  logic empty_s;
  logic req_out_s;
  logic grant_s;
  logic push_s;
  logic pop_s;
  logic spurious_s;
  logic head_owner_s;

  // Master selection: a pending lock wins, otherwise the tie-break applies.
  always_comb begin
    sel_id_s    = 1'b0;
    sel_valid_s = 1'b0;
    if (lock_valid_r) begin
      sel_id_s    = lock_id_r;
      sel_valid_s = lock_id_r ? m1.req : m0.req;
    end else if (m0.req && m1.req) begin
`ifdef ZERORISCY_DATA_ARB_RR_EN
      // The master that did not win the last grant takes the tie.
      sel_id_s    = ~last_gnt_r;
`else
      sel_id_s    = 1'b0;
`endif
      sel_valid_s = 1'b1;
    end else if (m1.req) begin
      sel_id_s    = 1'b1;
      sel_valid_s = 1'b1;
    end else begin
      sel_id_s    = 1'b0;
      sel_valid_s = m0.req;
    end
  end

  // FIFO status and handshake events. The full check uses the registered
  // count, so a pop in the same cycle does not unmask the request.
  always_comb begin
    full_s       = (count_r == CNT_MAX);
    empty_s      = (count_r == {CNT_W{1'b0}});
    req_out_s    = sel_valid_s && !full_s;
    grant_s      = req_out_s && data.gnt;
    push_s       = grant_s;
    pop_s        = data.rvalid && !empty_s;
    spurious_s   = data.rvalid && empty_s;
    head_owner_s = owner_r[rptr_r];
  end

  // Downstream request mux; all fields are zero while nothing is forwarded.
  always_comb begin
    data.req   = req_out_s;
    data.addr  = 32'h0000_0000;
    data.we    = 1'b0;
    data.be    = 4'b0000;
    data.wdata = 32'h0000_0000;
    if (req_out_s) begin
      if (sel_id_s) begin
        data.addr  = m1.addr;
        data.we    = m1.we;
        data.be    = m1.be;
        data.wdata = m1.wdata;
      end else begin
        data.addr  = m0.addr;
        data.we    = m0.we;
        data.be    = m0.be;
        data.wdata = m0.wdata;
      end
    end else begin
      data.addr  = 32'h0000_0000;
    end
  end

  // Grant and response routing back to the masters.
  always_comb begin
    m0.gnt    = grant_s && !sel_id_s;
    m1.gnt    = grant_s && sel_id_s;
    m0.rvalid = 1'b0;
    m1.rvalid = 1'b0;
    m0.err    = 1'b0;
    m1.err    = 1'b0;
    m0.rdata  = data.rdata;
    m1.rdata  = data.rdata;
    if (pop_s) begin
      if (head_owner_s) begin
        m1.rvalid = 1'b1;
        m1.err    = data.err;
      end else begin
        m0.rvalid = 1'b1;
        m0.err    = data.err;
      end
    end else begin
      m0.rvalid = 1'b0;
    end
  end

  // Lock register: keeps an ungranted downstream request on the same master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid_r <= 1'b0;
      lock_id_r    <= 1'b0;
    end else begin
      lock_valid_r <= req_out_s && !data.gnt;
      if (req_out_s) begin
        lock_id_r <= sel_id_s;
      end else begin
        lock_id_r <= lock_id_r;
      end
    end
  end

`ifdef ZERORISCY_DATA_ARB_RR_EN
  // Last-granted master; resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_r <= 1'b1;
    end else if (grant_s) begin
      last_gnt_r <= sel_id_s;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end
`endif

  // Owner FIFO: push on downstream grant, pop on rvalid; both may happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= {MAX_OUTSTANDING{1'b0}};
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        owner_r[wptr_r] <= sel_id_s;
        wptr_r          <= ptr_next(wptr_r);
      end else begin
        wptr_r          <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ptr_next(rptr_r);
      end else begin
        rptr_r <= rptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for responses that arrive with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spurious_r <= 1'b0;
    end else if (spurious_s) begin
      spurious_r <= 1'b1;
    end else begin
      spurious_r <= spurious_r;
    end
  end

  assign spurious_rvalid_o = spurious_r;

endmodule

// File: tb/tb_zeroriscy_data_arbiter.sv
module tb_zeroriscy_data_arbiter;
  localparam int unsigned MAXO = 2;

  logic clk;
  logic rst_n;
  logic spurious;

  zeroriscy_data_arbiter_if m0_if ();
  zeroriscy_data_arbiter_if m1_if ();
  zeroriscy_data_arbiter_if data_if ();

  zeroriscy_data_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .m0                (m0_if),
    .m1                (m1_if),
    .data              (data_if),
    .spurious_rvalid_o (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (rules-level, checked every cycle) -----
  bit m_lk_v;
  bit m_lk_id;
  bit m_last;
  bit m_spur;
  bit m_q[$];

  initial begin : model_cmp
    bit req0, req1, sel, any, dreq, grant, rv0, rv1;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_lk_v = 1'b0; m_lk_id = 1'b0; m_last = 1'b1; m_spur = 1'b0;
        m_q.delete();
        chk("rst_data_req", {31'd0, data_if.req}, 32'd0);
        chk("rst_gnts", {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);
        chk("rst_rvalids", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
        chk("rst_spurious", {31'd0, spurious}, 32'd0);
      end else begin
        req0 = m0_if.req;
        req1 = m1_if.req;
        if (m_lk_v) begin
          sel = m_lk_id;
          any = m_lk_id ? req1 : req0;
        end else if (req0 && req1) begin
`ifdef ZERORISCY_DATA_ARB_RR_EN
          sel = !m_last;
`else
          sel = 1'b0;
`endif
          any = 1'b1;
        end else begin
          sel = req1 && !req0;
          any = req0 || req1;
        end
        dreq    = any && (m_q.size() < MAXO);
        e_addr  = !dreq ? 32'd0 : (sel ? m1_if.addr  : m0_if.addr);
        e_we    = !dreq ? 1'b0  : (sel ? m1_if.we    : m0_if.we);
        e_be    = !dreq ? 4'd0  : (sel ? m1_if.be    : m0_if.be);
        e_wdata = !dreq ? 32'd0 : (sel ? m1_if.wdata : m0_if.wdata);
        grant   = dreq && data_if.gnt;
        rv0 = 1'b0;
        rv1 = 1'b0;
        if (data_if.rvalid && m_q.size() > 0) begin
          if (m_q[0]) rv1 = 1'b1;
          else        rv0 = 1'b1;
        end
        chk("data_req",   {31'd0, data_if.req}, {31'd0, dreq});
        chk("data_addr",  data_if.addr, e_addr);
        chk("data_we",    {31'd0, data_if.we}, {31'd0, e_we});
        chk("data_be",    {28'd0, data_if.be}, {28'd0, e_be});
        chk("data_wdata", data_if.wdata, e_wdata);
        chk("m0_gnt",     {31'd0, m0_if.gnt}, {31'd0, grant && !sel});
        chk("m1_gnt",     {31'd0, m1_if.gnt}, {31'd0, grant && sel});
        chk("m0_rvalid",  {31'd0, m0_if.rvalid}, {31'd0, rv0});
        chk("m1_rvalid",  {31'd0, m1_if.rvalid}, {31'd0, rv1});
        chk("m0_err",     {31'd0, m0_if.err}, {31'd0, rv0 && data_if.err});
        chk("m1_err",     {31'd0, m1_if.err}, {31'd0, rv1 && data_if.err});
        chk("m0_rdata",   m0_if.rdata, data_if.rdata);
        chk("m1_rdata",   m1_if.rdata, data_if.rdata);
        chk("spurious",   {31'd0, spurious}, {31'd0, m_spur});
        // state advance for the coming edge (inputs are stable until then)
        if (data_if.rvalid) begin
          if (m_q.size() > 0) void'(m_q.pop_front());
          else m_spur = 1'b1;
        end
        if (grant) begin
          m_q.push_back(sel);
          m_last = sel;
        end
        m_lk_v  = dreq && !data_if.gnt;
        m_lk_id = sel;
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setm(input int m, input bit req, input logic [31:0] addr,
                      input bit we, input logic [3:0] be, input logic [31:0] wdata);
    if (m == 0) begin
      m0_if.req = req; m0_if.addr = addr; m0_if.we = we; m0_if.be = be; m0_if.wdata = wdata;
    end else begin
      m1_if.req = req; m1_if.addr = addr; m1_if.we = we; m1_if.be = be; m1_if.wdata = wdata;
    end
  endtask

  task automatic idle();
    setm(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    setm(1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    data_if.gnt = 1'b0; data_if.rvalid = 1'b0; data_if.rdata = 32'd0; data_if.err = 1'b0;
  endtask

  // ---------------- directed tests with literal expectations --------------
  initial begin : stim
    bit exp0, prev0;
    rst_n = 1'b0;
    idle();
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_data_req", {31'd0, data_if.req}, 32'd0);
    chk("idle_addr", data_if.addr, 32'd0);

    // T1: both masters request every cycle, gnt tied 1, rvalid one cycle later
    prev0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      setm(0, 1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'd0);
      setm(1, 1'b1, 32'h0000_0200, 1'b0, 4'hF, 32'd0);
      data_if.gnt    = 1'b1;
      data_if.rvalid = (k > 0);
      data_if.rdata  = (k > 0) ? (32'hD000_0000 + k) : 32'd0;
      @(negedge clk);
`ifdef ZERORISCY_DATA_ARB_RR_EN
      exp0 = ((k % 2) == 0);
`else
      exp0 = 1'b1;
`endif
      chk("t1_m0_gnt", {31'd0, m0_if.gnt}, {31'd0, exp0});
      chk("t1_m1_gnt", {31'd0, m1_if.gnt}, {31'd0, !exp0});
      chk("t1_addr", data_if.addr, exp0 ? 32'h0000_0100 : 32'h0000_0200);
      if (k > 0) begin
        chk("t1_m0_rvalid", {31'd0, m0_if.rvalid}, {31'd0, prev0});
        chk("t1_m1_rvalid", {31'd0, m1_if.rvalid}, {31'd0, !prev0});
        chk("t1_rdata", prev0 ? m0_if.rdata : m1_if.rdata, 32'hD000_0000 + k);
      end
      prev0 = exp0;
    end
    cyc();
    idle();
    data_if.rvalid = 1'b1; data_if.rdata = 32'hD000_0006;
    @(negedge clk);
    chk("t1_drain_m0_rvalid", {31'd0, m0_if.rvalid}, {31'd0, prev0});

    // T2: m1 alone with gnt withheld 3 cycles, m0 joins in cycle 1
    cyc();
    idle();
    setm(1, 1'b1, 32'h0000_0200, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    chk("t2_c0_addr", data_if.addr, 32'h0000_0200);
    for (int k = 1; k < 3; k++) begin
      cyc();
      setm(0, 1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'd0);
      @(negedge clk);
      chk("t2_locked_addr", data_if.addr, 32'h0000_0200);
      chk("t2_no_m0_gnt", {31'd0, m0_if.gnt}, 32'd0);
    end
    cyc();
    data_if.gnt = 1'b1;
    @(negedge clk);
    chk("t2_c3_addr", data_if.addr, 32'h0000_0200);
    chk("t2_c3_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    cyc();
    setm(1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    chk("t2_c4_addr", data_if.addr, 32'h0000_0100);
    chk("t2_c4_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    cyc();
    idle();
    data_if.rvalid = 1'b1; data_if.rdata = 32'hAAAA_0001;
    @(negedge clk);
    chk("t2_resp1_m1", {31'd0, m1_if.rvalid}, 32'd1);
    cyc();
    data_if.rdata = 32'hAAAA_0002;
    @(negedge clk);
    chk("t2_resp2_m0", {31'd0, m0_if.rvalid}, 32'd1);

    // T3: FIFO full with rvalid withheld
    cyc();
    idle();
    setm(1, 1'b1, 32'h0000_0400, 1'b1, 4'b0011, 32'hCAFE_F00D);
    data_if.gnt = 1'b1;
    @(negedge clk);
    chk("t3_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    chk("t3_we", {31'd0, data_if.we}, 32'd1);
    chk("t3_be", {28'd0, data_if.be}, 32'd3);
    chk("t3_wdata", data_if.wdata, 32'hCAFE_F00D);
    cyc();
    setm(1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    setm(0, 1'b1, 32'h0000_0300, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    chk("t3_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      @(negedge clk);
      chk("t3_full_req", {31'd0, data_if.req}, 32'd0);
      chk("t3_full_gnt", {31'd0, m0_if.gnt}, 32'd0);
    end
    cyc();
    data_if.rvalid = 1'b1; data_if.rdata = 32'h1111_0001;
    @(negedge clk);
    chk("t3_first_resp_m1", {31'd0, m1_if.rvalid}, 32'd1);
    chk("t3_first_resp_not_m0", {31'd0, m0_if.rvalid}, 32'd0);
    chk("t3_masked_on_pop", {31'd0, data_if.req}, 32'd0);
    cyc();
    data_if.rvalid = 1'b0; data_if.rdata = 32'd0;
    @(negedge clk);
    chk("t3_regrant_m0", {31'd0, m0_if.gnt}, 32'd1);

    // T4: grant and rvalid in the same cycle with one outstanding
    cyc();
    setm(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    data_if.gnt = 1'b0; data_if.rvalid = 1'b1; data_if.rdata = 32'h2222_0001;
    @(negedge clk);
    chk("t4_pop_m0", {31'd0, m0_if.rvalid}, 32'd1);
    cyc();
    setm(1, 1'b1, 32'h0000_0500, 1'b0, 4'hF, 32'd0);
    data_if.gnt = 1'b1; data_if.rdata = 32'h2222_0002;
    @(negedge clk);
    chk("t4_same_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd1);
    chk("t4_same_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    cyc();
    idle();
    data_if.rvalid = 1'b1; data_if.rdata = 32'h2222_0003; data_if.err = 1'b1;
    @(negedge clk);
    chk("t4_next_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd1);
    chk("t4_next_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
    chk("t4_m1_err", {31'd0, m1_if.err}, 32'd1);
    chk("t4_m0_err", {31'd0, m0_if.err}, 32'd0);

    // T5: spurious rvalid with FIFO empty
    cyc();
    idle();
    data_if.rvalid = 1'b1;
    @(negedge clk);
    chk("t5_no_rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    cyc();
    data_if.rvalid = 1'b0;
    @(negedge clk);
    chk("t5_spurious_set", {31'd0, spurious}, 32'd1);
    cyc();
    @(negedge clk);
    chk("t5_spurious_sticky", {31'd0, spurious}, 32'd1);

    // T6: reset with two outstanding, then a stale response, then a tie
    cyc();
    setm(0, 1'b1, 32'h0000_0600, 1'b0, 4'hF, 32'd0);
    data_if.gnt = 1'b1;
    @(negedge clk);
    chk("t6_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    cyc();
    setm(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    setm(1, 1'b1, 32'h0000_0700, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    chk("t6_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    cyc();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_clears_spurious", {31'd0, spurious}, 32'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    cyc();
    data_if.rvalid = 1'b1; data_if.rdata = 32'h3333_0001;
    @(negedge clk);
    chk("t6_stale_dropped", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    cyc();
    data_if.rvalid = 1'b0; data_if.rdata = 32'd0;
    setm(0, 1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'd0);
    setm(1, 1'b1, 32'h0000_0200, 1'b0, 4'hF, 32'd0);
    data_if.gnt = 1'b1;
    @(negedge clk);
    chk("t6_spurious_after_reset", {31'd0, spurious}, 32'd1);
    chk("t6_tie_m0", {31'd0, m0_if.gnt}, 32'd1);
    chk("t6_tie_not_m1", {31'd0, m1_if.gnt}, 32'd0);
    cyc();
    idle();
    @(negedge clk);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zeroriscy_data_arbiter.md
# zeroriscy_data_arbiter

Two-master arbiter that shares the single data-memory port between the zero-riscy LSU (master 0) and a second master (master 1, e.g. the BNN accelerator load/store unit). It uses the core's req/gnt/rvalid protocol on both sides, with zero added latency on the request path. Outstanding transactions are tracked in an owner FIFO so each rvalid/rdata/err returns to the master that issued it. The block sits between the core/accelerator data ports and the data RAM or bus interconnect.

## Interface
- MAX_OUTSTANDING, 2: depth of the owner FIFO and the maximum number of granted transactions awaiting rvalid (1..4).
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- m0_req_i / m1_req_i  in  1  master request
- m0_addr_i / m1_addr_i  in  32  byte address
- m0_we_i / m1_we_i  in  1  write enable
- m0_be_i / m1_be_i  in  4  byte enables
- m0_wdata_i / m1_wdata_i  in  32  write data
- m0_gnt_o / m1_gnt_o  out  1  grant to master
- m0_rvalid_o / m1_rvalid_o  out  1  response valid to master
- m0_rdata_o / m1_rdata_o  out  32  read data; shared copy of data_rdata_i
- m0_err_o / m1_err_o  out  1  bus error qualified by rvalid
- data_req_o  out  1  downstream request
- data_addr_o  out  32  downstream address
- data_we_o  out  1  downstream write enable
- data_be_o  out  4  downstream byte enables
- data_wdata_o  out  32  downstream write data
- data_gnt_i  in  1  downstream grant
- data_rvalid_i  in  1  downstream response valid
- data_rdata_i  in  32  downstream read data
- data_err_i  in  1  downstream error
- spurious_rvalid_o  out  1  sticky flag: rvalid received with the owner FIFO empty

## Operation
- Protocol on every port:
  - A requester holds req and its address/data stable until gnt.
  - rvalid arrives one or more cycles after gnt, in order.
- Selection:
  - Only one master is forwarded per cycle. data_* carry the selected master's fields.
  - When no master is selected, data_req_o=0 and the other data_* outputs are 0.
- Lock:
  - If data_req_o=1 and data_gnt_i=0, the lock register captures the selected master.
  - The selection stays on that master until data_gnt_i=1, so the downstream request stays stable.
  - The lock clears in the cycle the grant occurs.
- Unlocked priority:
  - Round-robin: the master not granted most recently wins a tie.
  - A single requester always wins.
- Grant path: mX_gnt_o = data_gnt_i && data_req_o && (selected == X). Combinational.
- Owner FIFO:
  - Every downstream grant pushes the selected master ID.
  - Every data_rvalid_i pops the head, and rvalid/err go to the head owner. The non-owner's rvalid and err are 0.
  - Push and pop in the same cycle are both performed; the count is unchanged.
- FIFO full (count == MAX_OUTSTANDING):
  - data_req_o is forced to 0 and no grant is issued.
  - If a pop occurs in the same cycle, the request is still masked; the check uses the registered count.
- Spurious response: data_rvalid_i with the FIFO empty is dropped, and spurious_rvalid_o is set. The flag clears only on reset.
- Pointers are log2-sized and wrap modulo MAX_OUTSTANDING.

## Timing
- Request, address, data and grant paths are combinational master to downstream: zero cycles of latency.
- rvalid, rdata and err are combinational from the downstream port via the registered FIFO head.
- State registers: lock valid/ID, last-granted ID, FIFO entries, read/write pointers, count, spurious flag.
- Reset values:
  - Lock invalid; last-granted = 1, so master 0 wins the first tie.
  - FIFO empty; spurious_rvalid_o = 0.
  - All outputs 0 while both req inputs are 0.
- Reset mid-operation: all outstanding ownership is discarded. Responses after reset are treated as spurious.

## Configuration
- ZERORISCY_DATA_ARB_RR_EN defined: round-robin tie-break as above.
- ZERORISCY_DATA_ARB_RR_EN undefined:
  - Fixed priority, master 0 (core LSU) always wins when unlocked.
  - The last-granted register is not built.
  - The lock rule still applies.

## Test plan
- Both masters request at cycle 0, gnt tied 1, rvalid one cycle later, m0 addr 0x100 and m1 addr 0x200:
  - With the RR macro: grant order m0, m1, m0, m1 alternating. Each rdata returns to the matching master.
  - Without the macro: m0 is granted every cycle and m1 is starved.
- m1 requests alone and data_gnt_i is held 0 for 3 cycles; m0 requests in cycle 1. Required: data_addr_o stays on m1's address through the grant, and m0 is granted in the following cycle.
- MAX_OUTSTANDING=2, gnt=1, rvalid withheld. Required: two grants, then data_req_o=0 until the first rvalid. That rvalid goes to the first grantee.
- Grant and rvalid in the same cycle with count=1. Required: count remains 1, and the next rvalid goes to the newly granted master.
- data_rvalid_i pulsed with FIFO empty. Required: no mX_rvalid_o, and spurious_rvalid_o=1 until rst_n is asserted.
- rst_n asserted with 2 outstanding, then released, then rvalid. Required: no master rvalid and spurious flag set; the first tie after reset goes to m0.
